// File: rtl/shift_rf_feeder_pkg.sv
// Shared parameters, state encoding and sizing helpers for the shift RF feeder.
// The SHIFT_RF_2D row-word macro is the single definition of a packed RF row width.
`ifndef SHIFT_RF_2D_ROW_W
`define SHIFT_RF_2D_ROW_W(cols, bits) ((cols) * (bits))
`endif

package shift_rf_feeder_pkg;

  localparam int unsigned SHIFT_RF_NUM_COL  = 18;
  localparam int unsigned SHIFT_RF_NUM_ROW  = 16;
  localparam int unsigned SHIFT_RF_NUM_BITS = 10;
  localparam int unsigned IMG_ROWS_W        = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PRIME,
    ST_FILL,
    ST_SWEEP,
    ST_FIN
  } feeder_state_e;

  function automatic int unsigned row_width(input int unsigned num_col,
                                            input int unsigned num_bits);
    return `SHIFT_RF_2D_ROW_W(num_col, num_bits);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_rf_row_packer.sv
// Row packer: shifts accepted pixels into a NUM_COL-word row so the first pixel ends in
// word 0, and raises row_done_o for one cycle after the row's last pixel is taken.
module shift_rf_row_packer
  import shift_rf_feeder_pkg::*;
#(
  parameter int unsigned NUM_COL  = SHIFT_RF_NUM_COL,
  parameter int unsigned NUM_BITS = SHIFT_RF_NUM_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    clear_i,
  input  logic                                    accept_i,
  input  logic [NUM_BITS-1:0]                     pix_i,
  output logic [row_width(NUM_COL, NUM_BITS)-1:0] row_o,
  output logic                                    row_done_o
);

  localparam int unsigned ROW_W = row_width(NUM_COL, NUM_BITS);
  localparam int unsigned CNT_W = cnt_width(NUM_COL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COL - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    row_d  = row_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clear_i) begin
      row_d = '0;
      cnt_d = '0;
    end else if (accept_i) begin
      // New pixel enters the top word; after NUM_COL pixels the first one sits in word 0.
      row_d = {pix_i, row_q[ROW_W-1:NUM_BITS]};
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: the row register is reset too, since it drives the RF port directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      row_q  <= row_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign row_o      = row_q;
  assign row_done_o = done_q;

endmodule

// File: rtl/shift_rf_feeder.sv
// Feeds a 2-D shift register file: primes NUM_ROW rows, then alternates column sweeps
// with single-row refills until img_rows rows have passed through.
module shift_rf_feeder
  import shift_rf_feeder_pkg::*;
#(
  parameter int unsigned NUM_COL  = SHIFT_RF_NUM_COL,
  parameter int unsigned NUM_ROW  = SHIFT_RF_NUM_ROW,
  parameter int unsigned NUM_BITS = SHIFT_RF_NUM_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    start,
  input  logic [IMG_ROWS_W-1:0]                   img_rows,
  input  logic [NUM_BITS-1:0]                     pix_in,
  input  logic                                    pix_valid,
  output logic                                    pix_ready,
  output logic [row_width(NUM_COL, NUM_BITS)-1:0] row_data,
  output logic                                    row_shift,
  output logic                                    col_shift,
  output logic                                    rf_clear,
  output logic                                    win_valid,
  input  logic                                    win_ready,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
);

  localparam int unsigned COL_W = cnt_width(NUM_COL);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(NUM_COL - 1);
  localparam logic [IMG_ROWS_W-1:0] NUM_ROW_L = IMG_ROWS_W'(NUM_ROW);

  feeder_state_e         state_q, state_d;
  logic [IMG_ROWS_W-1:0] img_rows_q, img_rows_d;
  logic [IMG_ROWS_W-1:0] rows_loaded_q, rows_loaded_d;
  logic [COL_W-1:0]      col_pos_q, col_pos_d;
  logic                  err_q, err_d;
  logic                  row_shift_w;
  logic                  sweep_hs;

  shift_rf_row_packer #(
    .NUM_COL (NUM_COL),
    .NUM_BITS(NUM_BITS)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (rf_clear),
    .accept_i  (pix_valid & pix_ready),
    .pix_i     (pix_in),
    .row_o     (row_data),
    .row_done_o(row_shift_w)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      img_rows_q    <= '0;
      rows_loaded_q <= '0;
      col_pos_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      img_rows_q    <= img_rows_d;
      rows_loaded_q <= rows_loaded_d;
      col_pos_q     <= col_pos_d;
      err_q         <= err_d;
    end
  end

  assign sweep_hs = win_valid & win_ready;

  always_comb begin
    state_d       = state_q;
    img_rows_d    = img_rows_q;
    rows_loaded_d = rows_loaded_q;
    col_pos_d     = col_pos_q;
    err_d         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (img_rows >= NUM_ROW_L) begin
            img_rows_d = img_rows;
            state_d    = ST_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        rows_loaded_d = '0;
        col_pos_d     = '0;
        state_d       = ST_PRIME;
      end
      ST_PRIME: begin
        if (row_shift_w) begin
          rows_loaded_d = rows_loaded_q + IMG_ROWS_W'(1);
          if (rows_loaded_d == NUM_ROW_L) state_d = ST_SWEEP;
        end
      end
      ST_FILL: begin
        if (row_shift_w) begin
          rows_loaded_d = rows_loaded_q + IMG_ROWS_W'(1);
          state_d       = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (sweep_hs) begin
          // A full NUM_COL rotation returns the RF to its original column alignment.
          if (col_pos_q == COL_LAST) begin
            col_pos_d = '0;
            state_d   = (rows_loaded_q < img_rows_q) ? ST_FILL : ST_FIN;
          end else begin
            col_pos_d = col_pos_q + COL_W'(1);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    rf_clear  = 1'b0;
    win_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_CLEAR:          rf_clear  = 1'b1;
      ST_PRIME, ST_FILL: pix_ready = ~row_shift_w;
      ST_SWEEP:          win_valid = 1'b1;
      ST_FIN:            done      = 1'b1;
      default:           ;
    endcase
  end

  assign row_shift = row_shift_w;
  assign col_shift = sweep_hs;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_shift_rf_feeder.sv
// Scoreboard bench for shift_rf_feeder (NUM_COL=4, NUM_ROW=3, NUM_BITS=8): drivers push
// expected rows/frames/errors into queues, a negedge monitor pops and compares them.
module tb_shift_rf_feeder;

  localparam int NUM_COL  = 4;
  localparam int NUM_ROW  = 3;
  localparam int NUM_BITS = 8;
  localparam int ROW_W    = NUM_COL * NUM_BITS;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [9:0]          img_rows = '0;
  logic [NUM_BITS-1:0] pix_in = '0;
  logic                pix_valid = 1'b0;
  logic                win_ready = 1'b0;
  logic                pix_ready, row_shift, col_shift, rf_clear, win_valid, busy, done, err;
  logic [ROW_W-1:0]    row_data;

  always #5 clk = ~clk;

  shift_rf_feeder #(.NUM_COL(NUM_COL), .NUM_ROW(NUM_ROW), .NUM_BITS(NUM_BITS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .img_rows (img_rows),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .row_data (row_data),
    .row_shift(row_shift),
    .col_shift(col_shift),
    .rf_clear (rf_clear),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    int rows;
    int cols;
  } frame_t;

  frame_t           exp_frames[$];
  logic [ROW_W-1:0] exp_rows[$];
  int               exp_errs = 0;
  int               checks = 0;
  int               errors = 0;
  int               ready_mode = 0;
  int               done_count = 0;
  int               err_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window consumer: 0 = always ready, 1 = toggling 1/0, 2 = random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       win_ready = 1'b1;
      1:       win_ready = ~win_ready;
      default: win_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard.
  initial begin
    int  accepts = 0, rows_seen = 0, cols_seen = 0, clears_seen = 0;
    bit  shift_due = 0, prev_wait = 0, prev_done = 0, prev_err = 0;
    frame_t f;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        accepts = 0; rows_seen = 0; cols_seen = 0; clears_seen = 0;
        shift_due = 0; prev_wait = 0; prev_done = 0; prev_err = 0;
      end else begin
        if (row_shift || shift_due) check("row_shift_timing", 64'(row_shift), 64'(shift_due));
        if (row_shift) begin
          rows_seen++;
          if (exp_rows.size() == 0) check("row_unexpected", 64'(1), 64'(0));
          else check("row_data", 64'(row_data), 64'(exp_rows.pop_front()));
        end
        shift_due = 0;
        if (pix_valid && pix_ready) begin
          accepts++;
          if (accepts % NUM_COL == 0) shift_due = 1;
        end
        if (row_shift || col_shift || rf_clear)
          check("strobe_exclusive", 64'(int'(row_shift) + int'(col_shift) + int'(rf_clear)), 64'(1));
        if (win_valid || col_shift) check("col_shift_hs", 64'(col_shift), 64'(win_valid && win_ready));
        if (prev_wait) check("win_hold", 64'(win_valid), 64'(1));
        prev_wait = win_valid && !win_ready;
        if (col_shift) cols_seen++;
        if (rf_clear) clears_seen++;
        if (prev_err) check("err_pulse", 64'(err), 64'(0));
        prev_err = err;
        if (err) begin
          err_count++;
          if (exp_errs > 0) begin
            exp_errs--;
            check("err_busy", 64'(busy), 64'(0));
          end else check("err_unexpected", 64'(1), 64'(0));
        end
        if (prev_done) check("done_pulse", 64'(done), 64'(0));
        prev_done = done;
        if (done) begin
          done_count++;
          check("done_busy", 64'(busy), 64'(1));
          if (exp_frames.size() == 0) check("done_unexpected", 64'(1), 64'(0));
          else begin
            f = exp_frames.pop_front();
            check("frame_rows", 64'(rows_seen), 64'(f.rows));
            check("frame_cols", 64'(cols_seen), 64'(f.cols));
            check("frame_clears", 64'(clears_seen), 64'(1));
          end
          rows_seen = 0; cols_seen = 0; clears_seen = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int rows);
    start    = 1'b1;
    img_rows = 10'(rows);
    step();
    start = 1'b0;
  endtask

  // Sends n pixels; every NUM_COL pixels the expected packed row (word 0 = first) is queued.
  task automatic feed_pixels(input int n, input bit seq, input bit gaps);
    logic [NUM_BITS-1:0] words[NUM_COL];
    logic [ROW_W-1:0]    row;
    bit                  got;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
      pix_in    = seq ? NUM_BITS'(i + 1) : NUM_BITS'($urandom);
      pix_valid = 1'b1;
      got = 0;
      for (int w = 0; w < 400 && !got; w++) begin
        @(negedge clk);
        got = pix_ready;
        step();
      end
      if (!got) begin
        check("pix_accept_timeout", 64'(0), 64'(1));
        pix_valid = 1'b0;
        return;
      end
      words[i % NUM_COL] = pix_in;
      if (i % NUM_COL == NUM_COL - 1) begin
        row = '0;
        for (int k = 0; k < NUM_COL; k++) row = row | (ROW_W'(words[k]) << (k * NUM_BITS));
        exp_rows.push_back(row);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int rows, input int mode, input bit seq, input bit gaps,
                           input bit poke);
    frame_t f;
    int     d0;
    ready_mode = mode;
    f.rows = rows;
    f.cols = NUM_COL * (rows - NUM_ROW + 1);
    exp_frames.push_back(f);
    d0 = done_count;
    pulse_start(rows);
    if (poke) begin
      repeat (2) step();
      pulse_start(2);
    end
    feed_pixels(rows * NUM_COL, seq, gaps);
    for (int w = 0; w < 1000 && done_count == d0; w++) step();
    check("frame_done", 64'(done_count - d0), 64'(1));
    step();
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_pix_ready", 64'(pix_ready), 64'(0));
    check("rst_row_shift", 64'(row_shift), 64'(0));
    check("rst_col_shift", 64'(col_shift), 64'(0));
    check("rst_rf_clear", 64'(rf_clear), 64'(0));
    check("rst_win_valid", 64'(win_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_row_data", 64'(row_data), 64'(0));
  endtask

  initial begin
    int e0;
    #2;
    check_reset_outputs();
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Known pixels 0x01.. with pix_valid held high, consumer always ready.
    run_frame(3, 0, 1'b1, 1'b0, 1'b0);

    // Undersized image: err for one cycle, block stays idle.
    e0 = err_count;
    exp_errs++;
    pulse_start(2);
    repeat (3) step();
    check("bad_start_err", 64'(err_count - e0), 64'(1));
    check("bad_start_busy", 64'(busy), 64'(0));

    // Two refill phases with a toggling consumer; a stray start mid-frame is ignored.
    run_frame(5, 1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of priming, then a fresh frame.
    ready_mode = 0;
    pulse_start(3);
    feed_pixels(6, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    step();
    exp_rows.delete();
    exp_frames.delete();
    reset_n = 1'b1;
    step();
    run_frame(3, 0, 1'b1, 1'b0, 1'b0);

    // Randomized frames with pixel gaps and a random consumer.
    for (int n = 0; n < 4; n++)
      run_frame($urandom_range(NUM_ROW, NUM_ROW + 3), 2, 1'b0, 1'b1, 1'($urandom_range(0, 1)));

    check("rows_left", 64'(exp_rows.size()), 64'(0));
    check("frames_left", 64'(exp_frames.size()), 64'(0));
    check("errs_left", 64'(exp_errs), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
